// File: rtl/dly_pkg.sv
// Shared types and default widths for the delay pulse generator.
`timescale 1ns/1ps
package dly_pkg;

    localparam int unsigned DLY_NCH = 4;
    localparam int unsigned DLY_CW  = 15;
    localparam int unsigned DLY_WW  = 14;
    localparam int unsigned DLY_BW  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } dly_state_t;

endpackage

// File: rtl/dly_window.sv
// One registered pulse window: high while base+offset < cnt <= base+offset+width.
`timescale 1ns/1ps
module dly_window
    import dly_pkg::*;
#(
    parameter int unsigned CW = DLY_CW,
    parameter int unsigned WW = DLY_WW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          active,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] base,
    input  logic [CW-1:0] offset,
    input  logic [WW-1:0] width,
    input  logic          en,
    output logic          pulse
);

    logic [CW+1:0] cnt_x;
    logic [CW+1:0] width_x;
    logic [CW+1:0] win_start;
    logic [CW+1:0] win_stop;
    logic          hit;

    // Window bounds at two extra bits so start+width never wraps; cnt stops at
    // the period length, which truncates any window running past it.
    always_comb begin
        cnt_x              = '0;
        cnt_x[CW-1:0]      = cnt;
        width_x            = '0;
        width_x[WW-1:0]    = width;
        win_start          = {2'b00, base} + {2'b00, offset};
        win_stop           = win_start + width_x;
        hit                = active && en && (width != '0)
                             && (cnt_x > win_start) && (cnt_x <= win_stop);
    end

    // Register the decode so the output is glitch-free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pulse <= 1'b0;
        end else begin
            pulse <= hit;
        end
    end

endmodule

// File: rtl/delay_pulse_gen.sv
// Periodic tstart plus NCH delayed pulses relative to a TDC-tracked base delay.
`timescale 1ns/1ps
module delay_pulse_gen
    import dly_pkg::*;
#(
    parameter int unsigned NCH = DLY_NCH,
    parameter int unsigned CW  = DLY_CW,
    parameter int unsigned WW  = DLY_WW,
    parameter int unsigned BW  = DLY_BW
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic              burst_mode,
    input  logic [BW-1:0]     burst_len,
    input  logic              init,
    input  logic [CW-1:0]     cycle,
    input  logic [WW-1:0]     tstart_width,
    input  logic [CW-1:0]     base_delay,
    input  logic [NCH*CW-1:0] ch_offset,
    input  logic [NCH*WW-1:0] ch_width,
    input  logic [NCH-1:0]    ch_en,
    input  logic              tdc_valid,
    input  logic [CW-1:0]     tdc_data,
    output logic              tstart,
    output logic [NCH-1:0]    out,
    output logic              period_start,
    output logic              busy,
    output logic              burst_done,
    output logic              tdc_overrun
);

    dly_state_t        state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     pcount;

    logic [CW-1:0]     cycle_s;
    logic [WW-1:0]     tstart_width_s;
    logic [NCH*CW-1:0] ch_offset_s;
    logic [NCH*WW-1:0] ch_width_s;
    logic [NCH-1:0]    ch_en_s;
    logic              burst_mode_s;
    logic [BW-1:0]     burst_len_s;

    logic [CW-1:0]     pending_base;
    logic [CW-1:0]     active_base;
    logic              tdc_seen;

    logic              running;
    logic              start_go;
    logic              wrap;
    logic              boundary;
    logic [BW-1:0]     burst_len_eff;
    logic              last_burst;

    // Period boundary decode and burst-end test on the shadowed settings.
    always_comb begin
        running       = (state == RUN);
        start_go      = (state == IDLE) && run && (cycle != '0);
        wrap          = running && (cnt == cycle_s);
        boundary      = start_go || wrap;
        burst_len_eff = (burst_len_s == '0) ? BW'(1) : burst_len_s;
        last_burst    = burst_mode_s && (pcount == burst_len_eff);
    end

    // Control FSM: period counter, burst counting and registered status pulses.
    // A zero cycle captured at a wrap stops generation instead of letting cnt
    // run around its full range.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            pcount       <= '0;
            period_start <= 1'b0;
            busy         <= 1'b0;
            burst_done   <= 1'b0;
        end else begin
            period_start <= 1'b0;
            burst_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        state        <= RUN;
                        cnt          <= CW'(1);
                        pcount       <= BW'(1);
                        period_start <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        if (!run || (cycle == '0)) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (last_burst) begin
                            state      <= HOLD;
                            cnt        <= '0;
                            busy       <= 1'b0;
                            burst_done <= 1'b1;
                        end else begin
                            cnt          <= CW'(1);
                            pcount       <= pcount + 1'b1;
                            period_start <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!run) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers and active base: only updated on a period boundary.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_s        <= '0;
            tstart_width_s <= '0;
            ch_offset_s    <= '0;
            ch_width_s     <= '0;
            ch_en_s        <= '0;
            burst_mode_s   <= 1'b0;
            burst_len_s    <= '0;
            active_base    <= '0;
        end else if (boundary) begin
            cycle_s        <= cycle;
            tstart_width_s <= tstart_width;
            ch_offset_s    <= ch_offset;
            ch_width_s     <= ch_width;
            ch_en_s        <= ch_en;
            burst_mode_s   <= burst_mode;
            burst_len_s    <= burst_len;
            active_base    <= pending_base;
        end
    end

    // Pending base: init beats tdc_valid; a repeat tdc_valid within one
    // period sets the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending_base <= '0;
            tdc_overrun  <= 1'b0;
            tdc_seen     <= 1'b0;
        end else begin
            if (init) begin
                pending_base <= base_delay;
                tdc_overrun  <= 1'b0;
            end else if (tdc_valid) begin
                pending_base <= tdc_data;
                if (tdc_seen) begin
                    tdc_overrun <= 1'b1;
                end
            end
            if (boundary) begin
                tdc_seen <= 1'b0;
            end else if (tdc_valid && !init) begin
                tdc_seen <= 1'b1;
            end
        end
    end

    dly_window #(
        .CW(CW),
        .WW(WW)
    ) u_tstart (
        .clk    (clk),
        .resetn (resetn),
        .active (running),
        .cnt    (cnt),
        .base   ('0),
        .offset ('0),
        .width  (tstart_width_s),
        .en     (1'b1),
        .pulse  (tstart)
    );

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        dly_window #(
            .CW(CW),
            .WW(WW)
        ) u_win (
            .clk    (clk),
            .resetn (resetn),
            .active (running),
            .cnt    (cnt),
            .base   (active_base),
            .offset (ch_offset_s[gi*CW +: CW]),
            .width  (ch_width_s[gi*WW +: WW]),
            .en     (ch_en_s[gi]),
            .pulse  (out[gi])
        );
    end

endmodule

// File: tb/tb_delay_pulse_gen.sv
// Self-checking bench for delay_pulse_gen: period-level reference model plus
// hand-computed directed expectations.
`timescale 1ns/1ps
module tb_delay_pulse_gen;

    localparam int NCH = 4;
    localparam int CW  = 15;
    localparam int WW  = 14;
    localparam int BW  = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              run;
    logic              burst_mode;
    logic [BW-1:0]     burst_len;
    logic              init;
    logic [CW-1:0]     cycle;
    logic [WW-1:0]     tstart_width;
    logic [CW-1:0]     base_delay;
    logic [NCH*CW-1:0] ch_offset;
    logic [NCH*WW-1:0] ch_width;
    logic [NCH-1:0]    ch_en;
    logic              tdc_valid;
    logic [CW-1:0]     tdc_data;
    logic              tstart;
    logic [NCH-1:0]    out;
    logic              period_start;
    logic              busy;
    logic              burst_done;
    logic              tdc_overrun;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    delay_pulse_gen #(
        .NCH(NCH),
        .CW (CW),
        .WW (WW),
        .BW (BW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .run          (run),
        .burst_mode   (burst_mode),
        .burst_len    (burst_len),
        .init         (init),
        .cycle        (cycle),
        .tstart_width (tstart_width),
        .base_delay   (base_delay),
        .ch_offset    (ch_offset),
        .ch_width     (ch_width),
        .ch_en        (ch_en),
        .tdc_valid    (tdc_valid),
        .tdc_data     (tdc_data),
        .tstart       (tstart),
        .out          (out),
        .period_start (period_start),
        .busy         (busy),
        .burst_done   (burst_done),
        .tdc_overrun  (tdc_overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // pos = position inside the current period (0 = not generating),
    // held = burst finished and waiting for run to drop.
    int m_pos, m_held, m_periods, m_cyc, m_tw, m_bm, m_bl;
    int m_off[NCH];
    int m_w[NCH];
    int m_en[NCH];
    int m_act, m_pend, m_tdc_cnt, m_ovr;
    int pend_old, bl_eff, st;
    bit bnd;
    logic           e_tstart, e_ps, e_busy, e_done;
    logic [NCH-1:0] e_out;

    always @(posedge clk) begin
        if (!resetn) begin
            m_pos = 0; m_held = 0; m_periods = 0; m_cyc = 0; m_tw = 0;
            m_bm = 0; m_bl = 0; m_act = 0; m_pend = 0; m_tdc_cnt = 0; m_ovr = 0;
            for (int i = 0; i < NCH; i++) begin
                m_off[i] = 0; m_w[i] = 0; m_en[i] = 0;
            end
            e_tstart = 0; e_out = '0; e_ps = 0; e_busy = 0; e_done = 0;
        end else begin
            // outputs show the position held before this edge
            e_tstart = (m_pos >= 1) && (m_pos <= m_tw);
            for (int i = 0; i < NCH; i++) begin
                st = m_act + m_off[i];
                e_out[i] = (m_en[i] != 0) && (m_w[i] != 0) && (m_pos > st) && (m_pos <= st + m_w[i]);
            end
            e_done   = 0;
            bnd      = 0;
            pend_old = m_pend;
            if (m_held != 0) begin
                if (!run) m_held = 0;
            end else if (m_pos == 0) begin
                if (run && cycle != 0) begin
                    bnd = 1; m_pos = 1; m_periods = 1;
                end
            end else if (m_pos == m_cyc) begin
                bnd = 1;
                bl_eff = (m_bl == 0) ? 1 : m_bl;
                if (!run || cycle == 0) begin
                    m_pos = 0;
                end else if (m_bm != 0 && m_periods == bl_eff) begin
                    m_pos = 0; m_held = 1; e_done = 1;
                end else begin
                    m_pos = 1; m_periods++;
                end
            end else begin
                m_pos++;
            end
            if (bnd) begin
                m_cyc = int'(cycle); m_tw = int'(tstart_width);
                m_bm = int'(burst_mode); m_bl = int'(burst_len);
                for (int i = 0; i < NCH; i++) begin
                    m_off[i] = int'(ch_offset[i*CW +: CW]);
                    m_w[i]   = int'(ch_width[i*WW +: WW]);
                    m_en[i]  = int'(ch_en[i]);
                end
                m_act = pend_old;
            end
            if (init) begin
                m_pend = int'(base_delay); m_ovr = 0;
            end else if (tdc_valid) begin
                if (m_tdc_cnt > 0) m_ovr = 1;
                m_pend = int'(tdc_data);
            end
            if (bnd) m_tdc_cnt = 0;
            else if (tdc_valid && !init) m_tdc_cnt++;
            e_ps   = (m_pos == 1);
            e_busy = (m_pos != 0);
        end
    end

    // Single compare point, away from the active edge.
    always @(negedge clk) begin
        logic [8:0] act_v, exp_v;
        if (chk_on) begin
            act_v = {tstart, out, period_start, busy, burst_done, tdc_overrun};
            exp_v = {e_tstart, e_out, e_ps, e_busy, e_done, (m_ovr != 0)};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t {tstart,out,ps,busy,done,ovr} act=%b exp=%b", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Step until period_start is seen; n = steps taken.
    task automatic seek_ps(input string nm, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (period_start !== 1'b1 && n < 300);
        if (period_start !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting for period_start", nm);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (busy !== 1'b0 && n < 300);
        chk(nm, int'(busy), 0);
    endtask

    task automatic set_ch(input int i, input int off, input int w);
        ch_offset[i*CW +: CW] = CW'(off);
        ch_width[i*WW +: WW]  = WW'(w);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, ps_cnt, done_cnt, wait_n;
        resetn = 0; run = 0; burst_mode = 0; burst_len = '0; init = 0;
        cycle = '0; tstart_width = '0; base_delay = '0; ch_offset = '0;
        ch_width = '0; ch_en = '0; tdc_valid = 0; tdc_data = '0;
        step(3);
        chk_on = 1'b1;
        chk("reset_outputs", int'({tstart, out, period_start, busy, burst_done, tdc_overrun}), 0);
        resetn = 1;

        // 1: basic period
        cycle = 100; tstart_width = 5; base_delay = 10; set_ch(0, 0, 3); ch_en = 4'b0001;
        init = 1; step(1); init = 0;
        run = 1;
        seek_ps("t1_start", n);
        chk("t1_start_latency", n, 1);
        step(1);  chk("t1_tstart_c1", int'(tstart), 1);
        step(4);  chk("t1_tstart_c5", int'(tstart), 1);
        step(1);  chk("t1_tstart_c6", int'(tstart), 0);
        step(4);  chk("t1_out0_c10", int'(out[0]), 0);
        step(1);  chk("t1_out0_c11", int'(out[0]), 1);
        step(2);  chk("t1_out0_c13", int'(out[0]), 1);
        step(1);  chk("t1_out0_c14", int'(out[0]), 0);

        // 2: tdc update mid-period, then overrun
        step(6);  tdc_valid = 1; tdc_data = 40;
        step(1);  tdc_valid = 0;
        seek_ps("t2_next", n);
        chk("t2_period_len", n, 79);
        step(11); chk("t2_out0_c11", int'(out[0]), 0);
        step(30); chk("t2_out0_c41", int'(out[0]), 1);
        step(2);  chk("t2_out0_c43", int'(out[0]), 1);
        step(1);  chk("t2_out0_c44", int'(out[0]), 0);
        step(6);  tdc_valid = 1; tdc_data = 60;
        step(1);  tdc_valid = 0; chk("t2_ovr_first", int'(tdc_overrun), 0);
        step(1);  tdc_valid = 1; tdc_data = 70;
        step(1);  tdc_valid = 0; chk("t2_ovr_second", int'(tdc_overrun), 1);
        seek_ps("t2_last", n);
        step(61); chk("t2_out0_c61", int'(out[0]), 0);
        step(10); chk("t2_out0_c71", int'(out[0]), 1);

        // 3: window truncated at end of period
        step(4);  init = 1; base_delay = 95; set_ch(1, 0, 10); ch_en = 4'b0011;
        step(1);  init = 0; chk("t3_ovr_cleared", int'(tdc_overrun), 0);
        seek_ps("t3_start", n);
        step(95); chk("t3_out1_c95", int'(out[1]), 0);
        step(1);  chk("t3_out1_c96", int'(out[1]), 1);
        step(4);  chk("t3_out1_c100", int'(out[1]), 1);
        chk("t3_wrap_ps", int'(period_start), 1);
        step(1);  chk("t3_out1_next_c1", int'(out[1]), 0);
        step(4);  chk("t3_out1_next_c5", int'(out[1]), 0);

        // 5: mid-period changes apply at next wrap; disabled / zero-width channels
        cycle = 50; set_ch(0, 0, 6); set_ch(2, 0, 0); set_ch(3, 2, 5); ch_en = 4'b0111;
        init = 1; base_delay = 20;
        step(1); init = 0;
        seek_ps("t5_cur", n);
        chk("t5_cur_len", n, 94);
        seek_ps("t5_new", n);
        chk("t5_new_len", n, 50);
        step(21); chk("t5_out0_c21", int'(out[0]), 1);
        step(5);  chk("t5_out0_c26", int'(out[0]), 1);
        step(1);  chk("t5_out0_c27", int'(out[0]), 0);

        // 4: burst of three periods
        run = 0;
        wait_idle("t4_idle_before");
        burst_mode = 1; burst_len = 3; run = 1;
        ps_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 220; i++) begin
            step(1);
            if (period_start === 1'b1) ps_cnt++;
            if (burst_done === 1'b1) done_cnt++;
        end
        chk("t4_ps_count", ps_cnt, 3);
        chk("t4_done_count", done_cnt, 1);
        chk("t4_busy_after", int'(busy), 0);
        run = 0; step(2);
        chk("t4_busy_low", int'(busy), 0);
        run = 1;
        seek_ps("t4_restart", n);
        chk("t4_restart_latency", n, 1);
        run = 0; burst_mode = 0;
        wait_idle("t4_idle_after");

        // 6: reset mid-pulse, then init beats tdc_valid
        run = 1;
        wait_n = 0;
        do begin
            step(1);
            wait_n++;
        end while (out[0] !== 1'b1 && wait_n < 200);
        chk("t6_out0_seen", int'(out[0]), 1);
        resetn = 0; run = 0;
        step(1);
        chk("t6_reset_outputs", int'({tstart, out, period_start, busy, burst_done, tdc_overrun}), 0);
        resetn = 1;
        init = 1; base_delay = 7; tdc_valid = 1; tdc_data = 30; set_ch(0, 0, 3);
        step(1); init = 0; tdc_valid = 0;
        run = 1;
        seek_ps("t6_start", n);
        step(7);  chk("t6_out0_c7", int'(out[0]), 0);
        step(1);  chk("t6_out0_c8", int'(out[0]), 1);
        step(2);  chk("t6_out0_c10", int'(out[0]), 1);
        step(1);  chk("t6_out0_c11", int'(out[0]), 0);
        chk("t6_ovr", int'(tdc_overrun), 0);
        run = 0;
        wait_idle("t6_idle");
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
